chip_test_scheduler: RTL and testbench

Sequences the per-chip checker engines (one engine per supported 74-series part) that share the single DUT socket on the tester board. On a Run press it grants the socket to the selected engine, waits for the pin mux to settle, runs the engine, guards it with a timeout, and latches pass/fail for the display logic. It sits between the board buttons/switches and the bank of chip checker modules. The pin mux itself is external and is driven by the one-hot grant.

---
 rtl/chip_test_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_chip_test_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/chip_test_scheduler.sv
// Socket scheduler for the 74-series checker engines: grant, settle, run under a timeout, latch the result.
// Define CHIP_AUTOSCAN_EN to build in the autoscan over every engine (Scan=1 on the start edge).
module chip_test_scheduler #(
    parameter int NUM_CHIPS      = 8,
    parameter int SEL_W          = 3,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic [SEL_W-1:0]     Sel,
    input  logic                 Scan,
    output logic [NUM_CHIPS-1:0] ChkGrant,
    output logic [NUM_CHIPS-1:0] ChkRun,
    input  logic [NUM_CHIPS-1:0] ChkDone,
    input  logic [NUM_CHIPS-1:0] ChkRslt,
    output logic [NUM_CHIPS-1:0] ChkDisp,
    output logic                 Busy,
    output logic                 Done,
    output logic                 RSLT,
    output logic                 Timeout,
    output logic [SEL_W-1:0]     ResultId
);
    localparam int MAX_CYC = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W:0]   NUM_CHIPS_X  = (SEL_W + 1)'(NUM_CHIPS);
    localparam logic [SEL_W-1:0] LAST_IDX     = SEL_W'(NUM_CHIPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Out-of-range indices map to an all-zero mask, so they can never select an engine.
    function automatic logic [NUM_CHIPS-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [NUM_CHIPS-1:0] v;
        v = '0;
        for (int b = 0; b < NUM_CHIPS; b++) begin
            v[b] = (SEL_W'(b) == i);
        end
        return v;
    endfunction

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [SEL_W-1:0]     idx_r, idx_s;
    logic                 scan_r, scan_s;
    logic                 run_q_r;
    logic                 start_s;
    logic                 scan_en_s;
    logic [NUM_CHIPS-1:0] sel_mask_s;
    logic                 end_s, pass_s, expired_s;
    logic [NUM_CHIPS-1:0] grant_s, run_s, disp_s;
    logic                 busy_s, done_s, rslt_s, timeout_s;
    logic [SEL_W-1:0]     result_id_s;

`ifdef CHIP_AUTOSCAN_EN
    assign scan_en_s = Scan;
`else
    logic scan_unused_s;
    assign scan_unused_s = Scan;
    assign scan_en_s     = 1'b0;
`endif

    assign start_s    = Run & ~run_q_r;
    assign sel_mask_s = onehot(idx_r);

    // Next-state and next-output decode; every register holds unless a branch overrides it.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        scan_s      = scan_r;
        grant_s     = ChkGrant;
        run_s       = ChkRun;
        disp_s      = ChkDisp;
        busy_s      = Busy;
        done_s      = Done;
        rslt_s      = RSLT;
        timeout_s   = Timeout;
        result_id_s = ResultId;
        end_s       = 1'b0;
        pass_s      = 1'b0;
        expired_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_REPORT: begin
                if (start_s) begin
                    done_s    = 1'b0;
                    rslt_s    = 1'b0;
                    timeout_s = 1'b0;
                    disp_s    = '0;
                    run_s     = '0;
                    cnt_s     = '0;
                    if (scan_en_s) begin
                        scan_s  = 1'b1;
                        idx_s   = '0;
                        grant_s = onehot('0);
                        busy_s  = 1'b1;
                        state_s = ST_SETTLE;
                    end else if ({1'b0, Sel} >= NUM_CHIPS_X) begin
                        // No such engine: report a fail at once without touching the socket.
                        scan_s      = 1'b0;
                        idx_s       = Sel;
                        grant_s     = '0;
                        busy_s      = 1'b0;
                        done_s      = 1'b1;
                        result_id_s = Sel;
                        state_s     = ST_REPORT;
                    end else begin
                        scan_s  = 1'b0;
                        idx_s   = Sel;
                        grant_s = onehot(Sel);
                        busy_s  = 1'b1;
                        state_s = ST_SETTLE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    cnt_s   = '0;
                    run_s   = sel_mask_s;
                    state_s = ST_RUN;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Done from the granted engine takes priority over the timeout.
                if (|(ChkDone & sel_mask_s)) begin
                    end_s  = 1'b1;
                    pass_s = |(ChkRslt & sel_mask_s);
                end else if (cnt_r == TIMEOUT_LAST) begin
                    end_s     = 1'b1;
                    expired_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
                if (end_s) begin
                    run_s = '0;
                    cnt_s = '0;
                    if (scan_r && !pass_s && (idx_r != LAST_IDX)) begin
                        idx_s   = idx_r + SEL_W'(1);
                        grant_s = onehot(idx_r + SEL_W'(1));
                        state_s = ST_SETTLE;
                    end else begin
                        busy_s      = 1'b0;
                        done_s      = 1'b1;
                        rslt_s      = pass_s;
                        timeout_s   = expired_s;
                        result_id_s = idx_r;
                        disp_s      = sel_mask_s;
                        state_s     = ST_REPORT;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = '0;
                scan_s      = 1'b0;
                grant_s     = '0;
                run_s       = '0;
                disp_s      = '0;
                busy_s      = 1'b0;
                done_s      = 1'b0;
                rslt_s      = 1'b0;
                timeout_s   = 1'b0;
                result_id_s = '0;
            end
        endcase
    end

    // State, counters and registered outputs; Run_q resets high so a held Run cannot start a test.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            idx_r    <= '0;
            scan_r   <= 1'b0;
            run_q_r  <= 1'b1;
            ChkGrant <= '0;
            ChkRun   <= '0;
            ChkDisp  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            RSLT     <= 1'b0;
            Timeout  <= 1'b0;
            ResultId <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            scan_r   <= scan_s;
            run_q_r  <= Run;
            ChkGrant <= grant_s;
            ChkRun   <= run_s;
            ChkDisp  <= disp_s;
            Busy     <= busy_s;
            Done     <= done_s;
            RSLT     <= rslt_s;
            Timeout  <= timeout_s;
            ResultId <= result_id_s;
        end
    end

endmodule

// File: tb/tb_chip_test_scheduler.sv
// Directed bench for chip_test_scheduler: an 8-engine instance (timeout 100) and a 6-engine instance for the bad-index case.
module tb_chip_test_scheduler;
    logic       Clk;
    logic       Reset;
    logic       Run;
    logic [2:0] Sel;
    logic       Scan;
    logic [7:0] ChkDone, ChkRslt;
    logic [7:0] ChkGrant, ChkRun, ChkDisp;
    logic       Busy, Done, RSLT, Timeout;
    logic [2:0] ResultId;

    logic       run6;
    logic [2:0] sel6;
    logic [5:0] chk_done6, chk_rslt6;
    logic [5:0] grant6, crun6, disp6;
    logic       busy6, done6, rslt6, to6;
    logic [2:0] rid6;

    int n_tests = 0;
    int n_fail  = 0;
    int run_hi;
    logic [7:0] seen;
    logic [7:0] one;

    chip_test_scheduler #(.NUM_CHIPS(8), .SEL_W(3), .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Sel(Sel), .Scan(Scan),
        .ChkGrant(ChkGrant), .ChkRun(ChkRun), .ChkDone(ChkDone), .ChkRslt(ChkRslt),
        .ChkDisp(ChkDisp), .Busy(Busy), .Done(Done), .RSLT(RSLT), .Timeout(Timeout),
        .ResultId(ResultId)
    );

    chip_test_scheduler #(.NUM_CHIPS(6), .SEL_W(3), .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(100)) dut6 (
        .Clk(Clk), .Reset(Reset), .Run(run6), .Sel(sel6), .Scan(1'b0),
        .ChkGrant(grant6), .ChkRun(crun6), .ChkDone(chk_done6), .ChkRslt(chk_rslt6),
        .ChkDisp(disp6), .Busy(busy6), .Done(done6), .RSLT(rslt6), .Timeout(to6),
        .ResultId(rid6)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic stick;
        tick();
        seen = seen | ChkGrant;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Clk = 1'b0; Reset = 1'b1; Run = 1'b1; Sel = 3'd0; Scan = 1'b0;
        ChkDone = 8'h00; ChkRslt = 8'h00;
        run6 = 1'b1; sel6 = 3'd0; chk_done6 = 6'h00; chk_rslt6 = 6'h00;
        seen = 8'h00; one = 8'h01;
        tick(); tick();
        Reset = 1'b0;
        tick();
        check("reset_outs", {1'b0, ChkGrant, ChkRun, ChkDisp, Busy, Done, RSLT, Timeout, ResultId}, 32'h0);
        tick(); tick();
        check("run_held_no_start", {Busy, ChkGrant}, 32'h0);

        // Engine 2 passes after 40 RUN cycles; a stray done on engine 3 must be ignored.
        Run = 1'b0; Sel = 3'd2; tick();
        Run = 1'b1; tick();
        check("t1_grant", ChkGrant, 32'h04);
        check("t1_busy", {Busy, Done, ChkRun}, 32'h200);
        repeat (15) tick();
        check("t1_run_before", ChkRun, 32'h00);
        tick();
        check("t1_run_rise", ChkRun, 32'h04);
        ChkDone = 8'h08; ChkRslt = 8'h08;
        repeat (5) tick();
        check("t1_stray_done", {Done, ChkRun}, 32'h004);
        ChkDone = 8'h00; ChkRslt = 8'h00;
        repeat (34) tick();
        ChkDone = 8'h04; ChkRslt = 8'h04;
        tick();
        ChkDone = 8'h00; ChkRslt = 8'h00;
        check("t1_result", {Done, RSLT, Timeout, Busy, ResultId}, 32'b1100_010);
        check("t1_run_fall", ChkRun, 32'h00);
        check("t1_disp", ChkDisp, 32'h04);
        check("t1_grant_held", ChkGrant, 32'h04);
        tick();
        check("t1_report_hold", {Done, RSLT}, 32'b11);

        // Engine 5 never answers: RUN lasts exactly the timeout.
        Run = 1'b0; tick();
        Sel = 3'd5; Run = 1'b1; tick();
        check("t2_grant", ChkGrant, 32'h20);
        repeat (16) tick();
        run_hi = 0;
        for (int i = 0; i < 200 && !Done; i++) begin
            if (ChkRun == 8'h20) run_hi++;
            tick();
        end
        check("t2_run_cycles", run_hi, 32'd100);
        check("t2_result", {Done, RSLT, Timeout, ResultId}, 32'b101_101);
        check("t2_run_low", ChkRun, 32'h00);

        // Done on the very cycle the timeout would fire: done wins.
        Run = 1'b0; tick();
        ChkRslt = 8'h20; Run = 1'b1; tick();
        check("t3_cleared", {Done, RSLT, Timeout}, 32'b000);
        repeat (16) tick();
        repeat (99) tick();
        check("t3_last_run", ChkRun, 32'h20);
        ChkDone = 8'h20;
        tick();
        ChkDone = 8'h00; ChkRslt = 8'h00;
        check("t3_result", {Done, RSLT, Timeout, ResultId}, 32'b110_101);

        // Index 7 on a 6-engine scheduler: immediate fail, socket untouched.
        run6 = 1'b0; tick();
        sel6 = 3'd7; run6 = 1'b1; tick();
        check("t4_result", {done6, rslt6, to6, busy6, rid6}, 32'b1000_111);
        check("t4_socket", {grant6, crun6, disp6}, 32'h0);
        repeat (3) tick();
        check("t4_socket_hold", {grant6, crun6, done6}, 32'h1);

        // Reset with Run held, reset mid-RUN, and a second edge during SETTLE.
        Reset = 1'b1; tick();
        Reset = 1'b0;
        check("t5_reset_report", {1'b0, ChkGrant, ChkRun, ChkDisp, Busy, Done, RSLT, Timeout, ResultId}, 32'h0);
        repeat (3) tick();
        check("t5_no_start", {Busy, ChkGrant}, 32'h0);
        Run = 1'b0; tick();
        Sel = 3'd1; Run = 1'b1; tick();
        repeat (16) tick();
        check("t5_run1", ChkRun, 32'h02);
        repeat (5) tick();
        Reset = 1'b1; tick();
        check("t5_mid_run_reset", {1'b0, ChkGrant, ChkRun, ChkDisp, Busy, Done, RSLT, Timeout, ResultId}, 32'h0);
        Reset = 1'b0; tick();
        check("t5_after_reset_idle", {Busy, ChkGrant}, 32'h0);
        Run = 1'b0; tick();
        Sel = 3'd3; Run = 1'b1; tick();
        check("t5_grant3", ChkGrant, 32'h08);
        repeat (3) tick();
        Run = 1'b0; tick();
        Sel = 3'd6; Run = 1'b1; tick();
        check("t5_edge_ignored", {Busy, ChkGrant}, 32'h108);
        repeat (10) tick();
        check("t5_run_not_yet", ChkRun, 32'h00);
        tick();
        check("t5_run3", ChkRun, 32'h08);
        ChkDone = 8'h08; ChkRslt = 8'h00;
        tick();
        ChkDone = 8'h00;
        check("t5_fail_result", {Done, RSLT, Timeout, ResultId}, 32'b100_011);

        // Scan request: autoscan when built in, otherwise a plain test of Sel.
        Run = 1'b0; tick();
        Scan = 1'b1; Sel = 3'd4; Run = 1'b1; tick();
        seen = ChkGrant;
`ifdef CHIP_AUTOSCAN_EN
        check("t6_grant0", ChkGrant, 32'h01);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 100 && ChkRun != (one << k); w++) stick();
            check("t6_run_k", ChkRun, 32'(one << k));
            check("t6_grant_k", ChkGrant, 32'(one << k));
            stick(); stick();
            ChkDone = one << k;
            ChkRslt = (k == 3) ? (one << k) : 8'h00;
            stick();
            ChkDone = 8'h00; ChkRslt = 8'h00;
            check("t6_run_drop", ChkRun, 32'h00);
        end
        check("t6_result", {Done, RSLT, Timeout, ResultId}, 32'b110_011);
        check("t6_never_granted", seen[7:4], 32'h0);
`else
        check("t6_scan_ignored_grant", ChkGrant, 32'h10);
        repeat (16) stick();
        check("t6_run4", ChkRun, 32'h10);
        ChkDone = 8'h10; ChkRslt = 8'h10;
        tick();
        ChkDone = 8'h00; ChkRslt = 8'h00;
        check("t6_result", {Done, RSLT, Timeout, ResultId}, 32'b110_100);
        check("t6_only_engine4", seen, 32'h10);
`endif
        Scan = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
